render_scheduler: RTL and testbench
===================================

Name: render_scheduler

Overview:
Sequences the framebuffer renderer and shares the single main-RAM read port between the CPU and the renderer. On a vsync tick with a dirty display, it stalls the CPU, hands the read port to the renderer, pulses the renderer start, and waits for completion. It then returns the port to the CPU. It sits between the CPU core, the display timing generator, the renderer and main RAM.

Parameters:
ADDR_W, 12, main-RAM address width
MIN_RENDER_CYCLES, 4, cycles in RENDER during which render_finished is ignored (masks the renderer's stale finished level)
FRAME_CNT_W, 8, width of completed-frame counter
WATCHDOG_CYCLES, 1024, RENDER timeout (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
vsync  in  1  one-cycle pulse per display frame
dirty_set  in  1  one-cycle pulse; CPU modified the display area 0x100-0x1FF
cpu_ram_req  in  1  CPU has a main-RAM read in flight
cpu_ram_read_address  in  ADDR_W  CPU read address
cpu_stall  out  1  CPU must not issue new main-RAM reads
rnd_ram_read_address  in  ADDR_W  renderer read address
render_start  out  1  one-cycle start pulse to renderer
render_finished  in  1  renderer finished level
main_ram_read_address  out  ADDR_W  muxed main-RAM read address
busy  out  1  scheduler owns the port (GRANT..DONE)
frame_count  out  FRAME_CNT_W  completed renders, wraps
render_error  out  1  sticky watchdog flag (0 without the optional feature)

Behaviour:
- Reset values:
  - state=IDLE; cpu_stall=0; render_start=0; busy=0; frame_count=0; render_error=0.
  - vsync_pending=0; dirty=1, so the first vsync after reset renders.
- vsync_pending is set by vsync in any state and cleared only as stated below.
- dirty is set by dirty_set in any state and cleared on entry to START. If dirty_set coincides with the clear, set wins.
- IDLE:
  - vsync_pending and dirty -> GRANT.
  - vsync_pending and not dirty -> clear vsync_pending, stay in IDLE.
- GRANT:
  - cpu_stall=1 and busy=1 (registered; both assert in the first cycle of GRANT).
  - Stay while cpu_ram_req=1; go to START when cpu_ram_req=0.
- START: render_start=1 for exactly this cycle; clear dirty and vsync_pending; go to RENDER with the cycle counter reset to 0.
- RENDER:
  - Counter increments each cycle, saturating.
  - render_finished is ignored while counter < MIN_RENDER_CYCLES; afterwards render_finished=1 -> DONE.
- DONE: frame_count += 1 (wraps modulo 2^FRAME_CNT_W); cpu_stall=0 and busy=0 from the next cycle; -> IDLE.
- Port mux (combinational, zero latency): main_ram_read_address = rnd_ram_read_address in START and RENDER, otherwise cpu_ram_read_address.
- vsync arriving during GRANT..DONE: stays latched. If dirty_set also arrived during the render, the next frame renders immediately after IDLE; otherwise it is discarded in IDLE.
- render_start is never asserted outside START and never for more than one consecutive cycle.
- Reset mid-render: immediate return to reset values, port goes back to the CPU, stall released. The renderer is not informed.

Optional Feature:
RENDER_SCHEDULER_WATCHDOG_EN
- Defined: if the RENDER counter reaches WATCHDOG_CYCLES without an accepted render_finished, go to DONE without incrementing frame_count, set render_error (sticky until reset) and set dirty.
- Undefined: no timeout, the counter saturates at MIN_RENDER_CYCLES, and render_error is tied to 0.

Decomposition:
- Shared package render_pkg: state enum (IDLE, GRANT, START, RENDER, DONE), FB_SRC_BASE=12'h100, FB_SRC_LAST=12'h1FF, default ADDR_W.
- No sub-module needed; the watchdog stays inline.

Test Plan:
- Reset then vsync pulse, CPU idle -> GRANT 1 cycle, START next cycle, render_start high exactly 1 cycle, main_ram_read_address follows rnd address from START.
- render_finished held 1 from reset -> not accepted until 4 RENDER cycles elapse; drop then raise at cycle 300 -> DONE, frame_count=1, cpu_stall low one cycle after DONE.
- vsync with dirty=0 -> no render_start; vsync_pending cleared; cpu_stall stays 0.
- cpu_ram_req held high 5 cycles during GRANT -> START delayed until the cycle after req falls; mux never switches while req=1.
- dirty_set and vsync during RENDER -> second render starts right after IDLE, frame_count=2; vsync alone during RENDER -> no second render.
- reset asserted mid-RENDER -> all outputs at reset values immediately. With RENDER_SCHEDULER_WATCHDOG_EN and no finished for 1024 cycles -> render_error=1, frame_count unchanged.

Source files
------------

// File: rtl/render_pkg.sv
// Shared types and constants for the render scheduler: FSM state encoding,
// framebuffer source window bounds and the default main-RAM address width.
package render_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 12;

    localparam logic [11:0] FB_SRC_BASE = 12'h100;
    localparam logic [11:0] FB_SRC_LAST = 12'h1FF;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        RENDER,
        DONE
    } state_t;

endpackage

// File: rtl/render_scheduler.sv
// Frame render sequencer and main-RAM read-port arbiter between CPU and renderer.
// Optional RENDER timeout watchdog enabled by defining RENDER_SCHEDULER_WATCHDOG_EN.
module render_scheduler
    import render_pkg::*;
#(
    parameter int unsigned ADDR_W            = ADDR_W_DEFAULT,
    parameter int unsigned MIN_RENDER_CYCLES = 4,
    parameter int unsigned FRAME_CNT_W       = 8,
    parameter int unsigned WATCHDOG_CYCLES   = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vsync,
    input  logic                   dirty_set,
    input  logic                   cpu_ram_req,
    input  logic [ADDR_W-1:0]      cpu_ram_read_address,
    output logic                   cpu_stall,
    input  logic [ADDR_W-1:0]      rnd_ram_read_address,
    output logic                   render_start,
    input  logic                   render_finished,
    output logic [ADDR_W-1:0]      main_ram_read_address,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   render_error
);

    localparam int unsigned CNT_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_RENDER_CYCLES);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dirty_q, dirty_d;
    logic                   pending_q, pending_d;
    logic                   stall_q, stall_d;
    logic                   busy_q, busy_d;
    logic                   start_q, start_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic                   dirty_clr, pending_clr, dirty_force;

`ifdef RENDER_SCHEDULER_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_CNT = CNT_W'(WATCHDOG_CYCLES);
    logic timeout_q, timeout_d;
    logic error_q, error_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        dirty_clr   = 1'b0;
        pending_clr = 1'b0;
        dirty_force = 1'b0;
`ifdef RENDER_SCHEDULER_WATCHDOG_EN
        timeout_d   = timeout_q;
        error_d     = error_q;
`endif

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    if (dirty_q) state_d = GRANT;
                    else         pending_clr = 1'b1;
                end
            end
            GRANT: begin
                if (!cpu_ram_req) begin
                    state_d     = START;
                    dirty_clr   = 1'b1;
                    pending_clr = 1'b1;
                end
            end
            START: begin
                state_d = RENDER;
                cnt_d   = '0;
`ifdef RENDER_SCHEDULER_WATCHDOG_EN
                timeout_d = 1'b0;
`endif
            end
            RENDER: begin
                if (cnt_q >= MIN_CNT && render_finished) begin
                    state_d = DONE;
                end else begin
`ifdef RENDER_SCHEDULER_WATCHDOG_EN
                    if (cnt_q == WD_CNT) begin
                        state_d     = DONE;
                        timeout_d   = 1'b1;
                        error_d     = 1'b1;
                        dirty_force = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    if (cnt_q < MIN_CNT) cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef RENDER_SCHEDULER_WATCHDOG_EN
                if (!timeout_q) frame_d = frame_q + 1'b1;
`else
                frame_d = frame_q + 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Incoming pulses take priority over same-cycle clears.
        pending_d = (pending_q & ~pending_clr) | vsync;
        dirty_d   = (dirty_q & ~dirty_clr) | dirty_set | dirty_force;

        stall_d = (state_d != IDLE);
        busy_d  = (state_d != IDLE);
        start_d = (state_d == START);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dirty_q   <= 1'b1;
            pending_q <= 1'b0;
            stall_q   <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            frame_q   <= '0;
`ifdef RENDER_SCHEDULER_WATCHDOG_EN
            timeout_q <= 1'b0;
            error_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dirty_q   <= dirty_d;
            pending_q <= pending_d;
            stall_q   <= stall_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            frame_q   <= frame_d;
`ifdef RENDER_SCHEDULER_WATCHDOG_EN
            timeout_q <= timeout_d;
            error_q   <= error_d;
`endif
        end
    end

    assign cpu_stall    = stall_q;
    assign busy         = busy_q;
    assign render_start = start_q;
    assign frame_count  = frame_q;

`ifdef RENDER_SCHEDULER_WATCHDOG_EN
    assign render_error = error_q;
`else
    assign render_error = 1'b0;
`endif

    always_comb begin
        main_ram_read_address = cpu_ram_read_address;
        if (state_q == START || state_q == RENDER)
            main_ram_read_address = rnd_ram_read_address;
    end

endmodule

// File: tb/tb_render_scheduler.sv
// Directed self-checking bench for render_scheduler; inputs change and outputs
// are checked on the falling clock edge.
module tb_render_scheduler;

    localparam int unsigned ADDR_W = 12;
    localparam logic [ADDR_W-1:0] CPU_A = 12'h0AA;
    localparam logic [ADDR_W-1:0] RND_A = 12'h155;

    logic              clk = 1'b0;
    logic              reset;
    logic              vsync, dirty_set, cpu_ram_req, render_finished;
    logic [ADDR_W-1:0] cpu_addr, rnd_addr, main_addr;
    logic              cpu_stall, render_start, busy, render_error;
    logic [7:0]        frame_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    render_scheduler #(
        .ADDR_W(ADDR_W),
        .MIN_RENDER_CYCLES(4),
        .FRAME_CNT_W(8),
        .WATCHDOG_CYCLES(1024)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vsync(vsync),
        .dirty_set(dirty_set),
        .cpu_ram_req(cpu_ram_req),
        .cpu_ram_read_address(cpu_addr),
        .cpu_stall(cpu_stall),
        .rnd_ram_read_address(rnd_addr),
        .render_start(render_start),
        .render_finished(render_finished),
        .main_ram_read_address(main_addr),
        .busy(busy),
        .frame_count(frame_count),
        .render_error(render_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_stall"}, 32'(cpu_stall), 32'd0);
        chk({tag, "_start"}, 32'(render_start), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frames"}, 32'(frame_count), 32'd0);
        chk({tag, "_err"}, 32'(render_error), 32'd0);
        chk({tag, "_mux"}, 32'(main_addr), 32'(CPU_A));
    endtask

    initial begin
        reset = 1'b1; vsync = 1'b0; dirty_set = 1'b0; cpu_ram_req = 1'b0;
        render_finished = 1'b1; cpu_addr = CPU_A; rnd_addr = RND_A;
        #2;
        chk_reset_vals("rst");
        tick();
        reset = 1'b0;
        tick();

        // First vsync after reset renders because dirty resets to 1.
        vsync = 1'b1; tick(); vsync = 1'b0;
        chk("idle_stall", 32'(cpu_stall), 32'd0);
        tick();
        chk("grant_stall", 32'(cpu_stall), 32'd1);
        chk("grant_busy", 32'(busy), 32'd1);
        chk("grant_start", 32'(render_start), 32'd0);
        chk("grant_mux", 32'(main_addr), 32'(CPU_A));
        tick();
        chk("start_pulse", 32'(render_start), 32'd1);
        chk("start_mux", 32'(main_addr), 32'(RND_A));
        tick();
        chk("render_start_low", 32'(render_start), 32'd0);
        chk("render_mux", 32'(main_addr), 32'(RND_A));
        // Stale finished level must be masked for the first 4 RENDER cycles.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mask_busy", 32'(busy), 32'd1);
        end
        render_finished = 1'b0;
        for (int i = 0; i < 292; i++) tick();
        chk("long_busy", 32'(busy), 32'd1);
        chk("long_frames", 32'(frame_count), 32'd0);
        render_finished = 1'b1;
        tick();
        chk("done_stall", 32'(cpu_stall), 32'd1);
        chk("done_frames", 32'(frame_count), 32'd0);
        chk("done_mux", 32'(main_addr), 32'(CPU_A));
        tick();
        chk("post_stall", 32'(cpu_stall), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_frames", 32'(frame_count), 32'd1);

        // Clean display: vsync is discarded.
        vsync = 1'b1; tick(); vsync = 1'b0;
        tick();
        chk("clean_stall", 32'(cpu_stall), 32'd0);
        tick();
        chk("clean_stall2", 32'(cpu_stall), 32'd0);
        chk("clean_start", 32'(render_start), 32'd0);
        // A later dirty_set alone must not render if the pending vsync was dropped.
        dirty_set = 1'b1; tick(); dirty_set = 1'b0;
        tick();
        chk("pend_clr_stall", 32'(cpu_stall), 32'd0);
        tick();
        chk("pend_clr_stall2", 32'(cpu_stall), 32'd0);

        // CPU read in flight holds off START.
        cpu_ram_req = 1'b1;
        vsync = 1'b1; tick(); vsync = 1'b0;
        tick();
        chk("req_grant_stall", 32'(cpu_stall), 32'd1);
        chk("req_grant_mux", 32'(main_addr), 32'(CPU_A));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("req_hold_start", 32'(render_start), 32'd0);
            chk("req_hold_mux", 32'(main_addr), 32'(CPU_A));
        end
        cpu_ram_req = 1'b0;
        chk("req_fall_mux", 32'(main_addr), 32'(CPU_A));
        tick();
        chk("req_start", 32'(render_start), 32'd1);
        chk("req_start_mux", 32'(main_addr), 32'(RND_A));

        // dirty_set + vsync during RENDER: back-to-back render.
        tick();
        vsync = 1'b1; dirty_set = 1'b1; tick(); vsync = 1'b0; dirty_set = 1'b0;
        tick(); tick(); tick();
        tick();
        chk("r2_done_stall", 32'(cpu_stall), 32'd1);
        tick();
        chk("r2_idle_stall", 32'(cpu_stall), 32'd0);
        chk("r2_frames", 32'(frame_count), 32'd2);
        tick();
        chk("r3_grant_stall", 32'(cpu_stall), 32'd1);
        tick();
        chk("r3_start", 32'(render_start), 32'd1);

        // vsync alone during RENDER: no further render.
        tick();
        vsync = 1'b1; tick(); vsync = 1'b0;
        tick(); tick(); tick();
        tick();
        chk("r3_done_stall", 32'(cpu_stall), 32'd1);
        tick();
        chk("r3_idle_frames", 32'(frame_count), 32'd3);
        chk("r3_idle_stall", 32'(cpu_stall), 32'd0);
        tick();
        chk("r4_none_stall", 32'(cpu_stall), 32'd0);
        tick();
        chk("r4_none_stall2", 32'(cpu_stall), 32'd0);
        chk("r4_none_start", 32'(render_start), 32'd0);

        // Reset mid-RENDER.
        render_finished = 1'b0;
        vsync = 1'b1; dirty_set = 1'b1; tick(); vsync = 1'b0; dirty_set = 1'b0;
        tick(); tick(); tick(); tick();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_mux", 32'(main_addr), 32'(RND_A));
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        tick();
        reset = 1'b0;
        tick();

`ifdef RENDER_SCHEDULER_WATCHDOG_EN
        begin
            int unsigned waited;
            vsync = 1'b1; tick(); vsync = 1'b0;
            tick(); tick(); tick();
            chk("wd_render_busy", 32'(busy), 32'd1);
            waited = 0;
            while (busy === 1'b1 && waited < 1200) begin
                tick();
                waited++;
            end
            chk("wd_released", 32'(busy), 32'd0);
            chk("wd_error", 32'(render_error), 32'd1);
            chk("wd_frames", 32'(frame_count), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
